if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
// - Instruction-fetch front end: owns the PC, drives the combinational instruction ROM (ce/addr) and
//   captures the returned word the same cycle into a small fetch FIFO.
// - Presents {pc, inst} pairs to the IF/ID stage over a valid/ready handshake; handles branch and
//   flush redirects and traps misaligned targets. Sits between ctrl/EX (redirect sources) and IF/ID.
// PARAMETERS
// - RESET_PC    32'h0000_0000  first fetch address after reset
// - FIFO_DEPTH  2              fetch buffer entries (power of 2, >=2)
// - ADDR_W      32             PC / ROM address width
// - DATA_W      32             instruction width
// PORTS
// - clk              in   1       clock, all state on rising edge
// - rst              in   1       asynchronous, active-low reset
// - rom_ce_o         out  1       ROM chip enable (1 = enable)
// - rom_addr_o       out  ADDR_W  byte address to ROM (= current PC)
// - rom_inst_i       in   DATA_W  ROM read data, valid same cycle as addr
// - branch_flag_i    in   1       taken branch/jump from EX
// - branch_target_i  in   ADDR_W  branch target byte address
// - flush_i          in   1       pipeline flush (exception/eret), overrides branch
// - new_pc_i         in   ADDR_W  flush target byte address
// - id_ready_i       in   1       IF/ID can accept an entry this cycle
// - id_valid_o       out  1       head entry valid
// - id_pc_o          out  ADDR_W  head entry PC (0 when empty)
// - id_inst_o        out  DATA_W  head entry instruction (0 when empty)
// - fetch_fault_o    out  1       sticky misaligned-target fault
// BEHAVIOUR
// - Reset (async, immediate, no clock needed): pc=RESET_PC, state=IDLE, FIFO count=0, rom_ce_o=0,
//   id_valid_o=0, id_pc_o=0, id_inst_o=0, fetch_fault_o=0.
// - FSM: IDLE -> FETCH on first clk edge after reset release; FETCH -> FAULT on misaligned redirect;
//   FAULT only exits via reset.
// - rom_ce_o = (state==FETCH) && (count < FIFO_DEPTH), count sampled at start of cycle; rom_addr_o = pc.
// - Fetch: cycle with rom_ce_o=1 and no redirect -> at edge push {pc, rom_inst_i}, pc <= pc+4.
//   PC wraps 0xFFFF_FFFC -> 0x0000_0000.
// - Output: id_valid_o = (count != 0); id_pc_o/id_inst_o = head entry, zero when empty.
//   Pop at edge when id_valid_o && id_ready_i. Push+pop same cycle -> count unchanged, order kept.
// - Full: no push while count==FIFO_DEPTH, even if a pop occurs that cycle (one-cycle bubble;
//   DEPTH=2 still sustains 1 inst/cycle with ready held high).
// - Redirect priority: flush_i > branch_flag_i. On redirect at edge: FIFO cleared (count=0),
//   the in-flight ROM word is discarded, any pop that cycle is ignored, pc <= target.
// - Target check: target[1:0] != 0 -> state=FAULT, fetch_fault_o=1, FIFO cleared, pc unchanged,
//   rom_ce_o=0, id_valid_o=0 until reset.
// - Redirect inputs are ignored in IDLE and FAULT.
// - No combinational path from id_ready_i to rom_ce_o/rom_addr_o.
// TESTING
// - Reset release, RESET_PC=0, id_ready_i=1: cycle0 ce=0; then addr 0,4,8,...; id_pc_o 0,4,8 with
//   matching ROM words, 1/cycle.
// - id_ready_i=0 for 5 cycles from start: exactly pc 0,4 buffered, ce=0, addr holds 8;
//   release -> id_pc_o 0,4,8 in order, no loss or duplicate.
// - FIFO full (0,4), branch_flag_i=1 target 0x40: next cycle id_valid_o=0, addr=0x40;
//   following cycle id_pc_o=0x40.
// - flush_i (new_pc_i=0x80) and branch (0x40) same cycle -> addr=0x80; no 0x40 fetch ever occurs.
// - branch target 0x42 -> fetch_fault_o=1, ce=0, id_valid_o=0 for 10+ cycles; async rst low between
//   edges clears all outputs at once.
// - RESET_PC=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Bundle of ROM, redirect and IF/ID handshake signals for the fetch unit.
// The master side belongs to the fetch unit; the slave side belongs to its surroundings.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_inst_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              flush_i;
    logic [ADDR_W-1:0] new_pc_i;
    logic              id_ready_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [DATA_W-1:0] id_inst_o;
    logic              fetch_fault_o;

    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fetch_fault_o,
        input  rom_inst_i, branch_flag_i, branch_target_i, flush_i, new_pc_i, id_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fetch_fault_o,
        output rom_inst_i, branch_flag_i, branch_target_i, flush_i, new_pc_i, id_ready_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the combinational ROM and buffers
// {pc, inst} pairs in a small FIFO drained by IF/ID; redirects flush the buffer.
module if_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic            clk,
    input logic            rst,
    if_fetch_unit_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] r_pc_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] r_inst_mem [FIFO_DEPTH];

    logic              w_ce;
    logic              w_valid;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_misaligned;
    logic              w_push;
    logic              w_pop;

    // Fetch permission depends only on registered state, never on id_ready_i.
    assign w_ce         = (r_state == S_FETCH) && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_valid      = (r_count != '0);
    assign w_redirect   = (r_state == S_FETCH) && (bus.flush_i || bus.branch_flag_i);
    assign w_target     = bus.flush_i ? bus.new_pc_i : bus.branch_target_i;
    assign w_misaligned = w_redirect && (w_target[1:0] != 2'b00);
    assign w_push       = w_ce && !w_redirect;
    assign w_pop        = w_valid && bus.id_ready_i && !w_redirect;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: if (w_misaligned) w_state_next = S_FAULT;
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A redirect discards the in-flight word and any pop; a bad target leaves pc alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            if (!w_misaligned) begin
                r_pc <= w_target;
            end
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: head contents are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_pc;
            r_inst_mem[r_wr_ptr] <= bus.rom_inst_i;
        end
    end

    assign bus.rom_ce_o      = w_ce;
    assign bus.rom_addr_o    = r_pc;
    assign bus.id_valid_o    = w_valid;
    assign bus.id_pc_o       = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign bus.id_inst_o     = w_valid ? r_inst_mem[r_rd_ptr] : '0;
    assign bus.fetch_fault_o = (r_state == S_FAULT);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based reference model,
// plus a second instance checking PC wrap from a high reset address.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

    logic clk;
    logic rst;

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(HI_PC)) dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.rom_inst_i       = rom_fn(bus.rom_addr_o);
    assign bus2.rom_inst_i      = rom_fn(bus2.rom_addr_o);
    assign bus2.id_ready_i      = 1'b1;
    assign bus2.branch_flag_i   = 1'b0;
    assign bus2.flush_i         = 1'b0;
    assign bus2.branch_target_i = 32'h0;
    assign bus2.new_pc_i        = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: 0 = idle, 1 = fetching, 2 = faulted
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    logic        rdy, br, fl;
    logic [31:0] brt, npc;

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h0;
        q_pc.delete();
        q_inst.delete();
    endtask

    task automatic check_outputs();
        logic ce_e;
        logic [31:0] p_e, i_e;
        ce_e = (m_state == 1) && (q_pc.size() < DEPTH);
        p_e  = (q_pc.size() != 0) ? q_pc[0]   : 32'h0;
        i_e  = (q_pc.size() != 0) ? q_inst[0] : 32'h0;
        chk("rom_ce",   32'(bus.rom_ce_o),      32'(ce_e));
        chk("rom_addr", bus.rom_addr_o,         m_pc);
        chk("id_valid", 32'(bus.id_valid_o),    32'(q_pc.size() != 0));
        chk("id_pc",    bus.id_pc_o,            p_e);
        chk("id_inst",  bus.id_inst_o,          i_e);
        chk("fault",    32'(bus.fetch_fault_o), 32'(m_state == 2));
    endtask

    task automatic model_step();
        logic ce;
        logic [31:0] tgt;
        case (m_state)
            0: m_state = 1;
            1: begin
                ce = (q_pc.size() < DEPTH);
                if (fl || br) begin
                    tgt = fl ? npc : brt;
                    q_pc.delete();
                    q_inst.delete();
                    if (tgt[1:0] != 2'b00) m_state = 2;
                    else m_pc = tgt;
                end else begin
                    if (q_pc.size() != 0 && rdy) begin
                        void'(q_pc.pop_front());
                        void'(q_inst.pop_front());
                    end
                    if (ce) begin
                        q_pc.push_back(m_pc);
                        q_inst.push_back(rom_fn(m_pc));
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] nt);
        rdy = r; br = b; brt = bt; fl = f; npc = nt;
        bus.id_ready_i      = r;
        bus.branch_flag_i   = b;
        bus.branch_target_i = bt;
        bus.flush_i         = f;
        bus.new_pc_i        = nt;
    endtask

    // Asserts reset between edges, checks the immediate clear, releases on a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_target(input bit allow_mis);
        logic [31:0] t;
        t = $urandom() & 32'h0000_03FC;
        if ($urandom_range(0, 9) == 0) t = t | 32'hFFFF_FF00;
        if (allow_mis && $urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        int ready_pct[6];
        bit allow_mis;
        logic r, b, f;
        logic [31:0] bt, nt, e_addr;

        ready_pct = '{100, 70, 30, 10, 50, 90};
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();

        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            allow_mis = (ep == 4);
            for (int cyc = 0; cyc < 150; cyc++) begin
                r  = ($urandom_range(0, 99) < ready_pct[ep]);
                b  = ($urandom_range(0, 11) == 0);
                f  = ($urandom_range(0, 19) == 0);
                if (f && $urandom_range(0, 1) == 1) b = 1'b1;
                bt = rand_target(allow_mis);
                nt = rand_target(allow_mis);
                if (ep == 5 && cyc == 20) begin
                    b = 1'b1; f = 1'b0; bt = 32'h0000_0042;
                end
                drive(r, b, bt, f, nt);
                #1;
                check_outputs();
                model_step();
                @(negedge clk);
            end
        end

        // High reset address: fetch addresses must wrap through zero.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        apply_reset();
        #1;
        chk("hi_ce0",   32'(bus2.rom_ce_o), 32'h0);
        chk("hi_addr0", bus2.rom_addr_o,    HI_PC);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            if (k <= 4) begin
                e_addr = HI_PC + 32'(4 * (k - 1));
                chk("hi_ce",   32'(bus2.rom_ce_o), 32'h1);
                chk("hi_addr", bus2.rom_addr_o,    e_addr);
            end
            if (k >= 2) begin
                e_addr = HI_PC + 32'(4 * (k - 2));
                chk("hi_id_pc",   bus2.id_pc_o,   e_addr);
                chk("hi_id_inst", bus2.id_inst_o, rom_fn(e_addr));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
